// File: rtl/char_buf_arbiter.sv
// char_buf_arbiter
// Shares one single-port character RAM between four clients: the display
// fetch path, a bus write port, a bus read port and an optional clear engine.
// Exactly one access is granted per cycle, with fixed priority
// display > write > read > clear, decided combinationally from the requests
// present in that cycle.
//
// Optional feature: define CHARBUF_CLEAR_EN to build the clear engine (an
// IDLE/CLEAR/DONE sweep that fills every valid entry with one character).
// Without it, clr_busy_o/clr_done_o are tied low and clr_start_i/clr_char_i
// are ignored.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   disp_req_i, disp_addr_i       display fetch request/address
//   disp_data_o, disp_valid_o     display character, valid one cycle after grant
//   wr_req_i, wr_addr_i,
//   wr_data_i, wr_ack_o           bus write; ack is the grant cycle itself
//   rd_req_i, rd_addr_i,
//   rd_data_o, rd_valid_o         bus read; valid two cycles after grant
//   clr_start_i, clr_char_i,
//   clr_busy_o, clr_done_o        clear engine control/status
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i      single-port RAM, 1-cycle read latency
module char_buf_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2400
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              clr_start_i,
  input  logic [DATA_W-1:0] clr_char_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr <= LAST_ADDR;
  endfunction

  logic              disp_gnt;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              clr_gnt;
  logic              rd_busy;
  logic              clr_req;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_char;

  logic              disp_vld_p1;
  logic              disp_hit_p1;
  logic              rd_vld_p1;
  logic              rd_hit_p1;

  // A read stays outstanding until its rd_valid_o cycle; the requester still
  // holds rd_req_i during that cycle, so it must not be granted again there.
  assign rd_busy = rd_vld_p1 | rd_valid_o;

  // ---- stage p0: grant and RAM command ----
  always_comb begin
    disp_gnt = ~rst_i & disp_req_i;
    wr_gnt   = ~rst_i & ~disp_req_i & wr_req_i;
    rd_gnt   = ~rst_i & ~disp_req_i & ~wr_req_i & rd_req_i & ~rd_busy;
    // A read held off by an outstanding read does not block the sweep.
    clr_gnt  = ~rst_i & ~disp_req_i & ~wr_req_i & ~(rd_req_i & ~rd_busy) & clr_req;

    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (disp_gnt) begin
      mem_en_o   = in_range(disp_addr_i);
      mem_addr_o = disp_addr_i;
    end else if (wr_gnt) begin
      mem_en_o    = in_range(wr_addr_i);
      mem_we_o    = in_range(wr_addr_i);
      mem_addr_o  = wr_addr_i;
      mem_wdata_o = wr_data_i;
    end else if (rd_gnt) begin
      mem_en_o   = in_range(rd_addr_i);
      mem_addr_o = rd_addr_i;
    end else if (clr_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = clr_cnt;
      mem_wdata_o = clr_char;
    end
  end

  assign wr_ack_o = wr_gnt;

  // ---- stage p1: RAM data returns; display result, read capture ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_vld_p1 <= 1'b0;
      disp_hit_p1 <= 1'b0;
      rd_vld_p1   <= 1'b0;
      rd_hit_p1   <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      disp_vld_p1 <= disp_gnt;
      disp_hit_p1 <= disp_gnt & in_range(disp_addr_i);
      rd_vld_p1   <= rd_gnt;
      rd_hit_p1   <= rd_gnt & in_range(rd_addr_i);
      rd_valid_o  <= rd_vld_p1;
      if (rd_vld_p1) begin
        rd_data_o <= rd_hit_p1 ? mem_rdata_i : '0;
      end
    end
  end

  assign disp_valid_o = disp_vld_p1;
  assign disp_data_o  = disp_hit_p1 ? mem_rdata_i : '0;

`ifdef CHARBUF_CLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  clr_state_t clr_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_state  <= IDLE;
      clr_cnt    <= '0;
      clr_busy_o <= 1'b0;
      clr_done_o <= 1'b0;
    end else begin
      case (clr_state)
        IDLE: begin
          clr_done_o <= 1'b0;
          if (clr_start_i) begin
            clr_state  <= CLEAR;
            clr_cnt    <= '0;
            clr_busy_o <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter only moves on a granted slot, so the sweep simply stalls
          // behind higher-priority traffic and stops at the last valid entry.
          if (clr_gnt) begin
            if (clr_cnt == LAST_ADDR) begin
              clr_state  <= DONE;
              clr_done_o <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          clr_state  <= IDLE;
          clr_busy_o <= 1'b0;
          clr_done_o <= 1'b0;
        end
        default: begin
          clr_state  <= IDLE;
          clr_busy_o <= 1'b0;
          clr_done_o <= 1'b0;
        end
      endcase
    end
  end

  // Fill character is pure data, captured when a sweep is accepted.
  always_ff @(posedge clk_i) begin
    if (clr_state == IDLE && clr_start_i) begin
      clr_char <= clr_char_i;
    end
  end

  assign clr_req = (clr_state == CLEAR);
`else
  logic unused_clr;

  assign unused_clr = ^{clr_start_i, clr_char_i};
  assign clr_req    = 1'b0;
  assign clr_cnt    = '0;
  assign clr_char   = '0;
  assign clr_busy_o = 1'b0;
  assign clr_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Directed bench for char_buf_arbiter with a behavioural single-port RAM
// (1-cycle read latency) attached to the memory port. RAM entry i starts as
// (i & 0xFF) ^ 0xA5 so that untouched locations are distinguishable from 0.
module tb_char_buf_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2400;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clr_start;
  logic [DATA_W-1:0] clr_char;
  logic              clr_busy;
  logic              clr_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  char_buf_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(disp_data), .disp_valid_o(disp_valid),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .clr_start_i(clr_start), .clr_char_i(clr_char),
    .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= DATA_W'(i) ^ 8'hA5;
      mem_rdata <= '0;
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_fill(input logic [DATA_W-1:0] c);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== c) bad++;
    return bad;
  endfunction

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    wr_req = 1'b1; wr_addr = 12'd3; wr_data = 8'h99;
    rd_req = 1'b0; rd_addr = '0;
    clr_start = 1'b0; clr_char = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_clr_busy", clr_busy, 0);

    // write 0x41 to 0, read it back
    @(negedge clk); rst = 1'b0; wr_addr = 12'd0; wr_data = 8'h41; #1;
    chk("wr0_ack", wr_ack, 1);
    chk("wr0_we", mem_we, 1);
    chk("wr0_addr", mem_addr, 0);
    @(negedge clk); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 12'd0; #1;
    chk("wr0_ack_single", wr_ack, 0);
    chk("rd0_en", mem_en, 1);
    chk("rd0_we", mem_we, 0);
    @(negedge clk); #1;
    chk("rd0_valid_n1", rd_valid, 0);
    chk("rd0_block_n1", mem_en, 0);
    @(negedge clk); #1;
    chk("rd0_valid_n2", rd_valid, 1);
    chk("rd0_data", rd_data, 8'h41);
    chk("rd0_block_n2", mem_en, 0);
    @(negedge clk); rd_req = 1'b0; #1;
    chk("rd0_pulse", rd_valid, 0);
    chk("rd0_hold", rd_data, 8'h41);

    // display and write collide at address 5
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 12'd5;
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h43; #1;
    chk("coll_wr_ack", wr_ack, 0);
    chk("coll_we", mem_we, 0);
    chk("coll_en", mem_en, 1);
    @(negedge clk); disp_req = 1'b0; #1;
    chk("coll_disp_valid", disp_valid, 1);
    chk("coll_disp_data", disp_data, 8'hA0);
    chk("coll_wr_ack_next", wr_ack, 1);
    @(negedge clk); wr_req = 1'b0; disp_req = 1'b1; #1;
    chk("coll_disp_pulse", disp_valid, 0);
    chk("coll_disp_zero", disp_data, 0);
    @(negedge clk); disp_req = 1'b0; #1;
    chk("disp5_valid", disp_valid, 1);
    chk("disp5_data", disp_data, 8'h43);

    // out-of-range write, read and display
    @(negedge clk); wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 8'h55; #1;
    chk("oor_wr_ack", wr_ack, 1);
    chk("oor_wr_en", mem_en, 0);
    @(negedge clk); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 12'd2399; #1;
    chk("rd2399_en", mem_en, 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rd2399_valid", rd_valid, 1);
    chk("rd2399_data", rd_data, 8'hFA);
    @(negedge clk); rd_addr = 12'd2400; #1;
    chk("oor_rd_en", mem_en, 0);
    chk("oor_ram_untouched", ram[2400], 8'hC5);
    @(negedge clk); #1;
    chk("oor_rd_n1", rd_valid, 0);
    @(negedge clk); #1;
    chk("oor_rd_valid", rd_valid, 1);
    chk("oor_rd_data", rd_data, 0);
    @(negedge clk); rd_req = 1'b0; disp_req = 1'b1; disp_addr = 12'd2400; #1;
    chk("oor_disp_en", mem_en, 0);
    @(negedge clk); disp_req = 1'b0; #1;
    chk("oor_disp_valid", disp_valid, 1);
    chk("oor_disp_data", disp_data, 0);

    // same-cycle write and read to address 7
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 12'd7; wr_data = 8'h77;
    rd_req = 1'b1; rd_addr = 12'd7; #1;
    chk("wr_rd_ack", wr_ack, 1);
    chk("wr_rd_we", mem_we, 1);
    @(negedge clk); wr_req = 1'b0; #1;
    chk("wr_rd_rd_en", mem_en, 1);
    chk("wr_rd_rd_we", mem_we, 0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("wr_rd_valid", rd_valid, 1);
    chk("wr_rd_data", rd_data, 8'h77);

    // reset while a read is in flight
    @(negedge clk); rd_addr = 12'd5; #1;
    chk("rstrd_gnt", mem_en, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; rd_req = 1'b0; #1;
    chk("rstrd_no_valid", rd_valid, 0);
    chk("rstrd_data", rd_data, 0);
    @(negedge clk); #1;
    chk("rstrd_no_valid_late", rd_valid, 0);

`ifdef CHARBUF_CLEAR_EN
    // full sweep with 0x20
    @(negedge clk); clr_char = 8'h20; clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0; #1;
    chk("clr_busy", clr_busy, 1);
    chk("clr_first_addr", mem_addr, 0);
    n = 1;
    while (!clr_done && n < 3000) begin @(negedge clk); n++; end
    chk("clr_cycles", n, 2401);
    chk("clr_busy_done", clr_busy, 1);
    @(negedge clk); #1;
    chk("clr_done_pulse", clr_done, 0);
    chk("clr_busy_after", clr_busy, 0);
    chk("clr_fill", count_fill(8'h20), 0);
    chk("clr_oor_untouched", ram[2400], 8'hC5);

    // sweep stalled by display; mid-sweep start ignored
    @(negedge clk); clr_char = 8'h2E; clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0; disp_req = 1'b1; disp_addr = 12'd0;
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); n++;
      clr_start = (k == 4);
      clr_char  = (k == 4) ? 8'h99 : 8'h2E;
      if (k == 4) begin
        #1;
        chk("stall_no_we", mem_we, 0);
      end
    end
    disp_req = 1'b0; clr_start = 1'b0;
    while (!clr_done && n < 3000) begin @(negedge clk); n++; end
    chk("stall_cycles", n, 2411);
    @(negedge clk);
    chk("stall_fill", count_fill(8'h2E), 0);

    // reset in the middle of a sweep
    @(negedge clk); clr_char = 8'h30; clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    repeat (1000) @(negedge clk);
    #1;
    chk("abort_at_1000", mem_addr, 1000);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    seen = 0;
    repeat (5) begin @(negedge clk); seen = seen | int'(clr_done); end
    chk("abort_no_done", seen, 0);
    chk("abort_ram999", ram[999], 8'h30);
    chk("abort_ram1000", ram[1000], 8'h2E);
    clr_char = 8'h31; clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0; #1;
    chk("restart_addr", mem_addr, 0);
    chk("restart_wdata", mem_wdata, 8'h31);
    chk("restart_we", mem_we, 1);
`else
    @(negedge clk); clr_char = 8'h20; clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0; #1;
    chk("noclr_busy", clr_busy, 0);
    chk("noclr_mem_en", mem_en, 0);
    seen = 0;
    repeat (3) begin @(negedge clk); seen = seen | int'(clr_done) | int'(clr_busy); end
    chk("noclr_status", seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
